// File: rtl/axis_stream_checker.sv
// axis_stream_checker: AXI-Stream sink that compares accepted beats against an expected-word FIFO.
// Define AXIS_CHECK_HALT_EN to stop accepting beats after the first error (debug freeze).
module axis_stream_checker #(
    parameter int          C_S_AXIS_TDATA_WIDTH = 32,
    parameter int          EXP_DEPTH            = 16,
    parameter logic [15:0] STALL_SEED           = 16'hACE1
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    output logic                                s00_axis_tready,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                exp_valid,
    output logic                                exp_ready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     exp_data,
    input  logic                                exp_last,
    input  logic                                stall_en,
    output logic [31:0]                         word_count,
    output logic [15:0]                         pkt_count,
    output logic [15:0]                         err_count,
    output logic                                err,
    output logic [1:0]                          err_code,
    output logic                                in_pkt
);

    localparam int DW     = C_S_AXIS_TDATA_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int PTR_W  = $clog2(EXP_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(EXP_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DW:0]       mem [EXP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ, occ_d;
    logic [DW:0]       head;
    logic              fifo_empty;
    logic              acc, pop, push;
    logic [DW-1:0]     byte_mask;
    logic              data_err, last_err, beat_err;
    logic [1:0]        beat_code;
    logic              halt_d;
    logic [15:0]       lfsr;
    logic              lfsr_fb;

    assign fifo_empty = (occ == '0);
    assign head       = mem[rd_ptr];
    assign acc        = s00_axis_tvalid && s00_axis_tready;
    assign pop        = acc && !fifo_empty;
    // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
    assign push       = exp_valid && (exp_ready || pop);
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            byte_mask[i*8 +: 8] = {8{s00_axis_tstrb[i]}};
        end
    end

    always_comb begin
        data_err  = |((s00_axis_tdata ^ head[DW-1:0]) & byte_mask);
        last_err  = (s00_axis_tlast != head[DW]);
        beat_err  = acc && (fifo_empty || data_err || last_err);
        beat_code = 2'b10;
        if (fifo_empty) begin
            beat_code = 2'b11;
        end else if (data_err) begin
            beat_code = 2'b01;
        end
    end

    always_comb begin
        occ_d = occ;
        case ({push, pop})
            2'b10:   occ_d = occ + OCC_W'(1);
            2'b01:   occ_d = occ - OCC_W'(1);
            default: occ_d = occ;
        endcase
    end

    always_comb begin
`ifdef AXIS_CHECK_HALT_EN
        halt_d = err || beat_err;
`else
        halt_d = 1'b0;
`endif
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (push) begin
            mem[wr_ptr] <= {exp_last, exp_data};
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            exp_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ       <= occ_d;
            exp_ready <= (occ_d != FULL_OCC);
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            lfsr            <= STALL_SEED;
            s00_axis_tready <= 1'b0;
        end else begin
            if (stall_en) begin
                lfsr <= {lfsr[14:0], lfsr_fb};
            end
            s00_axis_tready <= !halt_d && !(stall_en && lfsr[1:0] == 2'b00);
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            word_count <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            if (acc && word_count != '1) begin
                word_count <= word_count + 32'd1;
            end
            if (acc && s00_axis_tlast && pkt_count != '1) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (beat_err && err_count != '1) begin
                err_count <= err_count + 16'd1;
            end
            if (beat_err) begin
                err <= 1'b1;
            end
            if (beat_err && !err) begin
                err_code <= beat_code;
            end
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (acc && !s00_axis_tlast) state_d = BODY;
            BODY: if (acc && s00_axis_tlast)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_pkt = (state_q == BODY);

endmodule

// File: tb/tb_axis_stream_checker.sv
// tb_axis_stream_checker: directed + randomized bench with a queue-based reference model.
// Honours AXIS_CHECK_HALT_EN the same way as the design.
module tb_axis_stream_checker;

    localparam int DEPTH = 16;
`ifdef AXIS_CHECK_HALT_EN
    localparam bit HALT      = 1'b1;
    localparam int T5_CYCLES = 400;
`else
    localparam bit HALT      = 1'b0;
    localparam int T5_CYCLES = 20000;
`endif

    logic        clk;
    logic        aresetn;
    logic        tready;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        stall_en;
    logic [31:0] word_count;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic        err;
    logic [1:0]  err_code;
    logic        in_pkt;

    axis_stream_checker #(
        .C_S_AXIS_TDATA_WIDTH(32),
        .EXP_DEPTH(DEPTH),
        .STALL_SEED(16'hACE1)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(aresetn),
        .s00_axis_tready(tready),
        .s00_axis_tvalid(tvalid),
        .s00_axis_tdata(tdata),
        .s00_axis_tstrb(tstrb),
        .s00_axis_tlast(tlast),
        .exp_valid(exp_valid),
        .exp_ready(exp_ready),
        .exp_data(exp_data),
        .exp_last(exp_last),
        .stall_en(stall_en),
        .word_count(word_count),
        .pkt_count(pkt_count),
        .err_count(err_count),
        .err(err),
        .err_code(err_code),
        .in_pkt(in_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference model: expected words as a queue plus plain counters.
    logic [32:0] mq[$];
    logic [31:0] m_word;
    logic [15:0] m_pkt;
    logic [15:0] m_errc;
    bit          m_err;
    logic [1:0]  m_code;
    bit          m_inpkt;
    bit          m_run;
    bit          m_tr_known;
    bit          m_tr;
    bit          m_acc, m_pop, m_push;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic modelStep();
        logic [31:0] mask;
        logic [32:0] hd;
        bit          berr;
        logic [1:0]  bcode;
        m_acc  = 1'b0;
        m_pop  = 1'b0;
        m_push = 1'b0;
        if (!aresetn) begin
            mq.delete();
            m_word = '0; m_pkt = '0; m_errc = '0;
            m_err = 1'b0; m_code = 2'b00; m_inpkt = 1'b0;
            m_run = 1'b0; m_tr_known = 1'b1; m_tr = 1'b0;
            return;
        end
        m_acc = tvalid && (tready === 1'b1);
        berr  = 1'b0;
        bcode = 2'b00;
        if (m_acc) begin
            if (mq.size() == 0) begin
                berr  = 1'b1;
                bcode = 2'b11;
            end else begin
                hd   = mq[0];
                mask = '0;
                for (int i = 0; i < 4; i++) if (tstrb[i]) mask[8*i +: 8] = 8'hFF;
                if (((hd[31:0] ^ tdata) & mask) != 32'd0) begin
                    berr = 1'b1; bcode = 2'b01;
                end else if (hd[32] != tlast) begin
                    berr = 1'b1; bcode = 2'b10;
                end
                m_pop = 1'b1;
            end
            if (m_word != 32'hFFFF_FFFF) m_word = m_word + 32'd1;
            if (tlast && m_pkt != 16'hFFFF) m_pkt = m_pkt + 16'd1;
            m_inpkt = !tlast;
        end
        m_push = exp_valid && m_run && (mq.size() < DEPTH || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back({exp_last, exp_data});
        if (berr) begin
            if (!m_err) m_code = bcode;
            m_err = 1'b1;
            if (m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
        end
        m_run = 1'b1;
        if (HALT && m_err) begin
            m_tr_known = 1'b1; m_tr = 1'b0;
        end else if (stall_en) begin
            m_tr_known = 1'b0;
        end else begin
            m_tr_known = 1'b1; m_tr = 1'b1;
        end
    endtask

    task automatic checkAll();
        checkOutput("word_count", word_count, m_word);
        checkOutput("pkt_count", pkt_count, 32'(m_pkt));
        checkOutput("err_count", err_count, 32'(m_errc));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("err_code", 32'(err_code), 32'(m_code));
        checkOutput("in_pkt", 32'(in_pkt), 32'(m_inpkt));
        checkOutput("exp_ready", 32'(exp_ready), 32'(m_run && mq.size() < DEPTH));
        if (m_tr_known) checkOutput("tready", 32'(tready), 32'(m_tr));
    endtask

    task automatic applyStimulus(input logic rn, input logic tv, input logic [31:0] td,
                                 input logic [3:0] ts, input logic tl, input logic ev,
                                 input logic [31:0] ed, input logic el, input logic se);
        aresetn = rn; tvalid = tv; tdata = td; tstrb = ts; tlast = tl;
        exp_valid = ev; exp_data = ed; exp_last = el; stall_en = se;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("rst_tready", 32'(tready), 32'd0);
        checkOutput("rst_exp_ready", 32'(exp_ready), 32'd0);
        checkOutput("rst_word_count", word_count, 32'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic pushWord(input logic [31:0] d, input logic l);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, d, l, 1'b0);
    endtask

    task automatic sendBeat(input logic [31:0] d, input logic [3:0] s, input logic l);
        applyStimulus(1'b1, 1'b1, d, s, l, 1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [32:0] words[1000];
    logic [32:0] bd;
    logic        tv_r;
    logic [3:0]  ts_r;
    int          pi, bi, saw0, saw1;

    initial begin
        aresetn = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0;
        exp_valid = 1'b0; exp_data = '0; exp_last = 1'b0; stall_en = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: eight-beat packet, all matching.
        doReset();
        checkOutput("t1_ready_after_reset", 32'(tready), 32'd1);
        for (int i = 1; i <= 8; i++) pushWord(32'(i), i == 8);
        for (int i = 1; i <= 8; i++) sendBeat(32'(i), 4'hF, i == 8);
        checkOutput("t1_word_count", word_count, 32'd8);
        checkOutput("t1_pkt_count", 32'(pkt_count), 32'd1);
        checkOutput("t1_err", 32'(err), 32'd0);
        checkOutput("t1_in_pkt", 32'(in_pkt), 32'd0);

        // Test 2: masked byte ignored, then the same beat unmasked is a data error.
        doReset();
        pushWord(32'hDEADBEEF, 1'b0);
        pushWord(32'hDEADBEEF, 1'b0);
        sendBeat(32'hDEAD00EF, 4'b1101, 1'b0);
        checkOutput("t2_masked_ok", 32'(err), 32'd0);
        sendBeat(32'hDEAD00EF, 4'hF, 1'b0);
        checkOutput("t2_err", 32'(err), 32'd1);
        checkOutput("t2_code", 32'(err_code), 32'd1);
        checkOutput("t2_err_count", 32'(err_count), 32'd1);

        // Data and last both wrong: counted once, coded as data.
        doReset();
        pushWord(32'h0000_1234, 1'b1);
        sendBeat(32'h0000_9999, 4'hF, 1'b0);
        checkOutput("both_code", 32'(err_code), 32'd1);
        checkOutput("both_err_count", 32'(err_count), 32'd1);

        // Test 3: missing tlast.
        doReset();
        pushWord(32'hA5A5A5A5, 1'b1);
        sendBeat(32'hA5A5A5A5, 4'hF, 1'b0);
        checkOutput("t3_code", 32'(err_code), 32'd2);
        checkOutput("t3_in_pkt", 32'(in_pkt), 32'd1);

        // Test 4: underflow with a same-cycle push (no bypass).
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h77, 4'hF, 1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
        checkOutput("t4_code", 32'(err_code), 32'd3);
        sendBeat(32'h55, 4'hF, 1'b1);
        checkOutput("t4_err_count", 32'(err_count), 32'd1);

        // Test 5: random stream with backpressure.
        doReset();
        for (int i = 0; i < 1000; i++) words[i] = {($urandom_range(7) == 0), 32'($urandom)};
        pi = 0; bi = 0; saw0 = 0; saw1 = 0;
        for (int cyc = 0; cyc < T5_CYCLES && bi < 1000; cyc++) begin
            tv_r = (mq.size() > 0) && ($urandom_range(3) != 0);
            bd   = (mq.size() > 0) ? mq[0] : 33'd0;
            ts_r = 4'($urandom_range(15));
            if (HALT && bi == 9) begin
                bd[0] = ~bd[0];
                ts_r  = 4'hF;
            end
            if (tready === 1'b1) saw1++;
            else if (tready === 1'b0) saw0++;
            applyStimulus(1'b1, tv_r, bd[31:0], ts_r, bd[32], pi < 1000,
                          (pi < 1000) ? words[pi][31:0] : 32'd0,
                          (pi < 1000) ? words[pi][32] : 1'b0, 1'b1);
            if (m_push) pi++;
            if (m_pop) bi++;
        end
        checkOutput("t5_tready_toggles", 32'(saw0 > 0 && saw1 > 0), 32'd1);
`ifdef AXIS_CHECK_HALT_EN
        checkOutput("t5_halt_word_count", word_count, 32'd10);
        checkOutput("t5_halt_tready", 32'(tready), 32'd0);
        checkOutput("t5_halt_code", 32'(err_code), 32'd1);
`else
        checkOutput("t5_word_count", word_count, 32'd1000);
        checkOutput("t5_err", 32'(err), 32'd0);
`endif

        // Test 6: full FIFO with simultaneous push/pop, drain, then reset mid-packet.
        doReset();
        for (int i = 0; i < DEPTH; i++) pushWord(32'h100 + 32'(i), 1'b0);
        checkOutput("t6_full", 32'(exp_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h100, 4'hF, 1'b0, 1'b1, 32'hCAFE, 1'b0, 1'b0);
        checkOutput("t6_full_after_pushpop", 32'(exp_ready), 32'd0);
        for (int i = 1; i < DEPTH; i++) sendBeat(32'h100 + 32'(i), 4'hF, 1'b0);
        sendBeat(32'hCAFE, 4'hF, 1'b0);
        checkOutput("t6_wrapped_ok", 32'(err), 32'd0);
        checkOutput("t6_in_pkt", 32'(in_pkt), 32'd1);
        pushWord(32'hBEEF, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'hBEEF, 4'hF, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("t6_rst_in_pkt", 32'(in_pkt), 32'd0);
        checkOutput("t6_rst_word_count", word_count, 32'd0);
        checkOutput("t6_rst_tready", 32'(tready), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        sendBeat(32'hBEEF, 4'hF, 1'b1);
        checkOutput("t6_fifo_discarded", 32'(err_code), 32'd3);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
